serial_load_ctrl: RTL and testbench
===================================

// Module: serial_load_ctrl
// PURPOSE
//  Serialiser/controller directly upstream of the mux-hold flip-flop chain.
//  Accepts a parallel word over a valid/ready handshake and drives it MSB-first
//  onto the chain's shared serial `data` input. Asserts `select` for exactly one
//  cycle per bit, then drops `select` so the chain holds its contents.
//  Optional even-parity bit appended after the LSB; synchronous abort supported.
// PARAMETERS
//  WIDTH      8  payload bits per word (>=2)
//  PARITY_EN  0  1: append even-parity bit (XOR of payload) after LSB
// PORTS
//  clk         in   1      rising-edge clock, the only clock
//  reset_n     in   1      asynchronous, active-low reset
//  load_data   in   WIDTH  word to serialise; sampled only on accept
//  load_valid  in   1      upstream word valid
//  load_ready  out  1      high only in IDLE; accept = load_valid & load_ready at clk edge
//  abort       in   1      synchronous abort of an in-progress shift
//  data        out  1      serial bit to chain (registered)
//  select      out  1      chain shift enable: 1=load `data`, 0=hold (registered)
//  busy        out  1      high in SHIFT and DONE
//  done        out  1      one-cycle pulse after last bit shifted
// BEHAVIOUR
//  Reset (reset_n=0, async, any state): state=IDLE, data=0, select=0,
//   load_ready=1, busy=0, done=0, shift reg=0, bit counter=0. Partial word is
//   discarded; chain keeps whatever bits it already took.
//  TOTAL = WIDTH + PARITY_EN. All outputs registered, no combinational paths
//   from inputs to outputs.
//  States: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE: load_ready=1, select=0, data=0. On accept: capture load_data, compute
//   parity=^load_data, counter=0, go SHIFT. Next cycle is the first SHIFT cycle.
//  SHIFT: select=1, data=current bit, MSB first, then parity bit if PARITY_EN.
//   Exactly TOTAL contiguous cycles with select=1. Counter advances one per
//   cycle. After bit TOTAL-1, go DONE.
//  DONE: one cycle; select=0, data=0, done=1, busy=1, load_ready=0; then IDLE.
//  Latency: accept edge -> first select=1 cycle = 1 cycle. Accept -> done pulse
//   = TOTAL+1 cycles. With load_valid held high, back-to-back words show a
//   2-cycle select-low gap (DONE + IDLE).
//  load_valid outside IDLE is ignored. load_data changes after accept have no effect.
//  abort: sampled only in SHIFT. Next cycle: select=0, data=0, state=IDLE, no
//   done pulse. Bits already shifted stay in the chain. Ignored in IDLE and DONE.
//  abort and the last-bit cycle in the same cycle: abort wins, no done.
//  Counter width = $clog2(TOTAL+1); no wrap inside a word.
// TESTING
//  T1 reset: assert reset_n=0 mid-cycle -> all outputs at reset values
//     immediately, without waiting for a clk edge; load_ready=1 after release.
//  T2 WIDTH=8 PARITY_EN=0, load 8'hA5 -> select=1 for 8 cycles,
//     data=1,0,1,0,0,1,0,1; done=1 on cycle 9 after accept.
//  T3 PARITY_EN=1, load 8'h07 -> 9 select cycles, data=0,0,0,0,0,1,1,1,1
//     (last bit = parity 1). Load 8'h03 -> parity bit 0.
//  T4 load_valid pulsed with 8'hFF during SHIFT of 8'h00 -> ignored; output
//     stays all zeros; load_ready=0 throughout.
//  T5 abort on 4th SHIFT cycle -> select=0 from the next cycle, no done pulse,
//     IDLE, load_ready=1. Also reset_n=0 on 5th bit -> same, asynchronously.
//  T6 end-to-end: 8 chained mux-hold flops, load_valid held high, words 8'h3C
//     then 8'hC3 -> after each done the chain reads the word (last flop=MSB);
//     2-cycle select gap between the words; chain unchanged while select=0.

Source files
------------

// File: rtl/serial_load_ctrl.sv
//------------------------------------------------------------------------------
// Module   : serial_load_ctrl
// Brief    : Takes a parallel word over valid/ready and shifts it MSB-first,
//            with optional even parity, into a mux-hold flip-flop chain.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_load_ctrl #(
  parameter int WIDTH     = 8,
  parameter int PARITY_EN = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             abort,
  output logic             data,
  output logic             select,
  output logic             busy,
  output logic             done
);

  localparam int TOTAL = WIDTH + PARITY_EN;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [TOTAL-1:0]  shreg_q, shreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              data_q, data_d;
  logic              select_q, select_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic [TOTAL-1:0]  frame;
  logic              accept;

  // The frame is the payload followed by its even-parity bit when enabled.
  generate
    if (PARITY_EN != 0) begin : g_parity
      assign frame = {load_data, ^load_data};
    end else begin : g_no_parity
      assign frame = load_data;
    end
  endgenerate

  assign accept = load_valid & ready_q;

  // Next-state logic computes the outputs of the coming cycle so they can be
  // registered alongside the state.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    data_d   = 1'b0;
    select_d = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    ready_d  = 1'b0;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          state_d  = SHIFT;
          shreg_d  = frame;
          cnt_d    = '0;
          data_d   = frame[TOTAL-1];
          select_d = 1'b1;
          busy_d   = 1'b1;
          ready_d  = 1'b0;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
          shreg_d = '0;
          cnt_d   = '0;
          ready_d = 1'b1;
        end else if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b1;
        end else begin
          shreg_d  = shreg_q << 1;
          cnt_d    = cnt_q + CW'(1);
          data_d   = shreg_d[TOTAL-1];
          select_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      data_q   <= 1'b0;
      select_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      select_q <= select_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign load_ready = ready_q;
  assign data       = data_q;
  assign select     = select_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_load_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_serial_load_ctrl
// Brief    : Directed bench for serial_load_ctrl, without and with parity.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_serial_load_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] ld0 = '0, ld1 = '0;
  logic       vld0 = 1'b0, vld1 = 1'b0;
  logic       ab0 = 1'b0, ab1 = 1'b0;
  logic       rdy0, dat0, sel0, busy0, done0;
  logic       rdy1, dat1, sel1, busy1, done1;
  logic [7:0] chain = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_load_ctrl #(.WIDTH(8), .PARITY_EN(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .load_data(ld0), .load_valid(vld0),
    .load_ready(rdy0), .abort(ab0), .data(dat0), .select(sel0),
    .busy(busy0), .done(done0)
  );

  serial_load_ctrl #(.WIDTH(8), .PARITY_EN(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .load_data(ld1), .load_valid(vld1),
    .load_ready(rdy1), .abort(ab1), .data(dat1), .select(sel1),
    .busy(busy1), .done(done1)
  );

  // Eight mux-hold flops fed by the unparitied controller; chain[7] is the far end.
  always @(posedge clk) begin
    if (sel0) chain <= {chain[6:0], dat0};
  end

  typedef struct {
    logic       p;
    logic [7:0] word;
    int         n;
    logic [8:0] bits;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic o_sel(input logic p);  return p ? sel1  : sel0;  endfunction
  function automatic logic o_dat(input logic p);  return p ? dat1  : dat0;  endfunction
  function automatic logic o_rdy(input logic p);  return p ? rdy1  : rdy0;  endfunction
  function automatic logic o_busy(input logic p); return p ? busy1 : busy0; endfunction
  function automatic logic o_done(input logic p); return p ? done1 : done0; endfunction

  task automatic drive(input logic p, input logic v, input logic [7:0] d);
    if (p) begin vld1 = v; ld1 = d; end
    else   begin vld0 = v; ld0 = d; end
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int p = 0; p < 2; p++) begin
      chk({tag, "_rdy"},  o_rdy(p[0]),  1'b1);
      chk({tag, "_sel"},  o_sel(p[0]),  1'b0);
      chk({tag, "_dat"},  o_dat(p[0]),  1'b0);
      chk({tag, "_busy"}, o_busy(p[0]), 1'b0);
      chk({tag, "_done"}, o_done(p[0]), 1'b0);
    end
  endtask

  // Full word: one-cycle valid pulse, then TOTAL select cycles, DONE, IDLE.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk("pre_rdy", o_rdy(v.p), 1'b1);
    drive(v.p, 1'b1, v.word);
    @(negedge clk);
    drive(v.p, 1'b0, 8'h5A);
    for (int i = 0; i < v.n; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("w%02h_sel%0d", v.word, i), o_sel(v.p), 1'b1);
      chk($sformatf("w%02h_bit%0d", v.word, i), o_dat(v.p), v.bits[8-i]);
      chk($sformatf("w%02h_rdy%0d", v.word, i), o_rdy(v.p), 1'b0);
      chk($sformatf("w%02h_done%0d", v.word, i), o_done(v.p), 1'b0);
    end
    @(negedge clk);
    chk("done_pulse", o_done(v.p), 1'b1);
    chk("done_sel",   o_sel(v.p),  1'b0);
    chk("done_busy",  o_busy(v.p), 1'b1);
    chk("done_rdy",   o_rdy(v.p),  1'b0);
    @(negedge clk);
    chk("idle_done", o_done(v.p), 1'b0);
    chk("idle_rdy",  o_rdy(v.p),  1'b1);
    chk("idle_busy", o_busy(v.p), 1'b0);
  endtask

  task automatic wait_done0(input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      if (done0) break;
      @(negedge clk);
    end
    if (i == bound) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'hA5, 8, 9'b101001010};
    vecs[1] = '{1'b0, 8'h3C, 8, 9'b001111000};
    vecs[2] = '{1'b0, 8'h00, 8, 9'b000000000};
    vecs[3] = '{1'b1, 8'h07, 9, 9'b000001111};
    vecs[4] = '{1'b1, 8'h03, 9, 9'b000000110};
    vecs[5] = '{1'b1, 8'hFF, 9, 9'b111111110};
    vecs[6] = '{1'b1, 8'h80, 9, 9'b100000001};

    // Reset state after release.
    repeat (2) @(negedge clk);
    chk_reset_vals("rst_hold");
    reset_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_rel");

    foreach (vecs[k]) run_vec(vecs[k]);

    // valid pulsed with FF while 00 is shifting must be ignored.
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h00);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      chk("ign_sel", sel0, 1'b1);
      chk("ign_dat", dat0, 1'b0);
      chk("ign_rdy", rdy0, 1'b0);
      if (i == 2) drive(1'b0, 1'b1, 8'hFF);
      if (i == 3) drive(1'b0, 1'b0, 8'h00);
    end
    @(negedge clk);
    chk("ign_done", done0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("ign_nostart", sel0, 1'b0);

    // Abort on the 4th shift cycle.
    drive(1'b0, 1'b1, 8'hFF);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("ab_sel", sel0, 1'b1);
    end
    ab0 = 1'b1;
    @(negedge clk);
    ab0 = 1'b0;
    chk("ab_sel_off", sel0, 1'b0);
    chk("ab_dat",     dat0, 1'b0);
    chk("ab_rdy",     rdy0, 1'b1);
    chk("ab_busy",    busy0, 1'b0);
    chk("ab_done",    done0, 1'b0);
    @(negedge clk);
    chk("ab_nodone", done0, 1'b0);
    chk("ab_idle",   sel0,  1'b0);

    // Abort coinciding with the last bit wins over done (parity unit, bit 9).
    drive(1'b1, 1'b1, 8'h01);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h00);
    repeat (8) @(negedge clk);
    chk("ablast_sel", sel1, 1'b1);
    chk("ablast_par", dat1, 1'b1);
    ab1 = 1'b1;
    @(negedge clk);
    ab1 = 1'b0;
    chk("ablast_done", done1, 1'b0);
    chk("ablast_rdy",  rdy1,  1'b1);
    @(negedge clk);
    chk("ablast_done2", done1, 1'b0);

    // Asynchronous reset in the middle of the 5th bit on both units.
    drive(1'b0, 1'b1, 8'hFF);
    drive(1'b1, 1'b1, 8'hFF);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    repeat (4) @(negedge clk);
    chk("ar_sel_pre", sel0, 1'b1);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("ar");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ar_rdy", rdy0, 1'b1);

    // End-to-end chain with valid held high: 3C then C3 back to back.
    drive(1'b0, 1'b1, 8'h3C);
    @(negedge clk);
    drive(1'b0, 1'b1, 8'hC3);
    wait_done0(20);
    chk("e2e_w0", chain, 8'h3C);
    @(negedge clk);
    chk("e2e_gap_sel", sel0, 1'b0);
    chk("e2e_gap_hold", chain, 8'h3C);
    @(negedge clk);
    chk("e2e_second_start", sel0, 1'b1);
    wait_done0(20);
    drive(1'b0, 1'b0, 8'h00);
    chk("e2e_w1", chain, 8'hC3);
    @(negedge clk);
    @(negedge clk);
    chk("e2e_hold", chain, 8'hC3);
    chk("e2e_end_sel", sel0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
